// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receiver.
//   - CLKS_PER_BIT constants per baud/clock pair
//   - frame geometry (1 start + 8 data + 1 parity + 1 stop)
//   - parity encoding (EVEN = 0, ODD = 1)
//   - receiver FSM state type
package uart_rx_pkg;

    localparam int unsigned CLKS_6M_24M = 4;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + 1 + 1;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Parity bit a transmitter with the given setting would send for data.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input bit mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle of the UART receiver.
//   rx          serial line (idles high, asynchronous to clk)
//   rx_data     last received byte
//   rx_valid    one-clock strobe per completed frame
//   parity_err  parity mismatch on the last frame (held)
//   frame_err   stop bit sampled 0 on the last frame (held)
//   rx_busy     frame reception in progress
// master: the receiver (consumes rx, drives results); slave: line driver / consumer.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the asynchronous rx line.
//   clk, reset  system clock, asynchronous active-high reset (flops reset to 1 = idle line)
//   rx          raw line input
//   rx_s        synchronised line, used for edge/level decisions
//   rx_sample   value to use at a bit sample point
// Build option UART_RX_MAJORITY_EN: rx_sample is a 2-of-3 majority over rx_s
// and its two previous values; otherwise rx_sample is rx_s.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_sample
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist[0] = rx_s one cycle ago, hist[1] = two cycles ago.
    logic [1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '1;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    always_comb begin
        rx_sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
    end
`else
    always_comb begin
        rx_sample = rx_s;
    end
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, frame = start(0), 8 data LSB first, parity, stop(1).
// Samples at mid-bit by counting system clocks (no oversampling).
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    uart_rx_if.master: rx in; rx_data, rx_valid, parity_err,
//          frame_err, rx_busy out (all registered)
// Parameters: CLKS_PER_BIT (>= 3) clocks per bit; PARITY 0 = even, 1 = odd.
// Build option UART_RX_MAJORITY_EN (in uart_rx_sync): 2-of-3 majority sampling.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_6M_24M,
    parameter bit          PARITY       = PARITY_EVEN
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;
    logic rx_sample;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx        (bus.rx),
        .rx_s      (rx_s),
        .rx_sample (rx_sample)
    );

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 rx_busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt       <= '0;
                        state     <= ST_START;
                        rx_busy_q <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_sample) begin
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state     <= ST_IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sample, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IW'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_PARITY;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sample;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        rx_data_q    <= shift;
                        rx_valid_q   <= 1'b1;
                        parity_err_q <= (par_bit != parity_of(shift, PARITY));
                        frame_err_q  <= !rx_sample;
                        if (rx_sample) begin
                            state     <= ST_IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            // Break or misframe: wait for the line to go idle
                            // so a held-low line cannot retrigger frames.
                            state <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state     <= ST_IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT = 4, even parity).
// A line driver serialises frames; a monitor records every rx_valid strobe;
// each test task compares the recorded strobes against expectations computed
// from the frame contents (bit counting for parity, stop bit for framing,
// latency/spacing from the bit period).
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned CPB       = 4;
    localparam bit          PAR       = 1'b0;
    localparam int unsigned HALF      = CPB / 2;
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;
    // Line start driven at a negedge -> strobe seen at the negedge this many
    // clocks later: 2 sync flops + 1 detect edge + half bit + 10 bit periods.
    localparam int unsigned LAT       = 3 + HALF + 10 * CPB;
    // rx_busy stays high from the detect edge up to the stop sample edge.
    localparam int unsigned BUSY_CYC  = HALF + 10 * CPB;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY(PAR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t        obs[$];
    int unsigned busy_cycles = 0;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1)
            obs.push_back('{cyc, bus.rx_data, bus.parity_err, bus.frame_err});
        if (bus.rx_busy === 1'b1)
            busy_cycles++;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference parity bit: count ones; even parity makes the total even.
    function automatic logic ref_parity(input logic [7:0] d);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return ((ones % 2) == 1) ^ PAR;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              output int unsigned start_cyc);
        logic [10:0] f;
        f = {sbit, pbit, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            bus.rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int unsigned n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
        reset = 1'b0;
        obs.delete();
        idle(4 * CPB);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL reset_idle_strobes: got %0d expected 0", obs.size()); end
    endtask

    task automatic test_basic();
        logic [7:0]  d;
        int unsigned c0;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            obs.delete();
            busy_cycles = 0;
            send_frame(d, ref_parity(d), 1'b1, c0);
            idle(CPB + 4);
            checks++; if (obs.size() != 1) begin errors++; $display("FAIL basic_count[%0d]: got %0d expected 1", n, obs.size()); end
            if (obs.size() > 0) begin
                checks++; if (obs[0].data !== d) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", n, obs[0].data, d); end
                checks++; if (obs[0].perr !== 1'b0) begin errors++; $display("FAIL basic_perr[%0d]: got %b expected 0", n, obs[0].perr); end
                checks++; if (obs[0].ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr[%0d]: got %b expected 0", n, obs[0].ferr); end
                checks++; if (obs[0].cyc != c0 + LAT) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", n, obs[0].cyc - c0, LAT); end
            end
            checks++; if (busy_cycles != BUSY_CYC) begin errors++; $display("FAIL basic_busy_len[%0d]: got %0d expected %0d", n, busy_cycles, BUSY_CYC); end
            checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end[%0d]: got %b expected 0", n, bus.rx_busy); end
        end
    endtask

    task automatic test_parity_err();
        logic [7:0]  d;
        logic        pb;
        logic        exp_perr;
        int unsigned c0;
        for (int n = 0; n < 4; n++) begin
            d  = (n == 0) ? 8'h01 : 8'($urandom_range(0, 255));
            pb = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            exp_perr = (pb != ref_parity(d));
            obs.delete();
            send_frame(d, pb, 1'b1, c0);
            idle(CPB + 4);
            checks++; if (obs.size() != 1) begin errors++; $display("FAIL perr_count[%0d]: got %0d expected 1", n, obs.size()); end
            if (obs.size() > 0) begin
                checks++; if (obs[0].data !== d) begin errors++; $display("FAIL perr_data[%0d]: got %h expected %h", n, obs[0].data, d); end
                checks++; if (obs[0].perr !== exp_perr) begin errors++; $display("FAIL perr_flag[%0d]: got %b expected %b", n, obs[0].perr, exp_perr); end
                checks++; if (obs[0].ferr !== 1'b0) begin errors++; $display("FAIL perr_ferr[%0d]: got %b expected 0", n, obs[0].ferr); end
            end
            checks++; if (bus.parity_err !== exp_perr) begin errors++; $display("FAIL perr_held[%0d]: got %b expected %b", n, bus.parity_err, exp_perr); end
        end
    endtask

    task automatic test_framing();
        int unsigned c0;
        obs.delete();
        send_frame(8'h3C, ref_parity(8'h3C), 1'b0, c0);
        repeat (40) @(negedge clk);
        checks++; if (obs.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", obs.size()); end
        if (obs.size() > 0) begin
            checks++; if (obs[0].data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", obs[0].data); end
            checks++; if (obs[0].ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", obs[0].ferr); end
            checks++; if (obs[0].perr !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b expected 0", obs[0].perr); end
        end
        checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b expected 1", bus.rx_busy); end
        idle(2 * CPB);
        checks++; if (obs.size() != 1) begin errors++; $display("FAIL ferr_no_retrigger: got %0d expected 1", obs.size()); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_high: got %b expected 0", bus.rx_busy); end
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b expected 1", bus.frame_err); end
        send_frame(8'h55, ref_parity(8'h55), 1'b1, c0);
        idle(CPB + 4);
        checks++; if (obs.size() != 2) begin errors++; $display("FAIL ferr_next_count: got %0d expected 2", obs.size()); end
        if (obs.size() > 1) begin
            checks++; if (obs[1].data !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h expected 55", obs[1].data); end
            checks++; if ({obs[1].perr, obs[1].ferr} !== 2'b00) begin errors++; $display("FAIL ferr_next_flags: got %b%b expected 00", obs[1].perr, obs[1].ferr); end
        end
    endtask

    task automatic test_glitch();
        obs.delete();
        busy_cycles = 0;
        bus.rx = 1'b0;
        @(negedge clk);
        idle(3 * CPB);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL glitch_strobes: got %0d expected 0", obs.size()); end
        checks++; if (busy_cycles != HALF) begin errors++; $display("FAIL glitch_busy_len: got %0d expected %0d", busy_cycles, HALF); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", bus.rx_busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals[3];
        int unsigned c0[3];
        vals = '{8'h00, 8'hFF, 8'h7E};
        obs.delete();
        for (int i = 0; i < 3; i++) send_frame(vals[i], ref_parity(vals[i]), 1'b1, c0[i]);
        idle(CPB + 4);
        checks++; if (obs.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", obs.size()); end
        if (obs.size() == 3) begin
            checks++; if (obs[0].cyc != c0[0] + LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", obs[0].cyc - c0[0], LAT); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs[i].data !== vals[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs[i].data, vals[i]); end
                checks++; if ({obs[i].perr, obs[i].ferr} !== 2'b00) begin errors++; $display("FAIL b2b_flags[%0d]: got %b%b expected 00", i, obs[i].perr, obs[i].ferr); end
                if (i > 0) begin
                    checks++; if (obs[i].cyc - obs[i-1].cyc != FRAME_CYC) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, obs[i].cyc - obs[i-1].cyc, FRAME_CYC); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        int unsigned c0;
        f = {1'b1, ref_parity(8'h81), 8'h81, 1'b0};
        obs.delete();
        for (int i = 0; i < 4; i++) begin
            bus.rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = f[4];
        repeat (HALF) @(negedge clk);
        checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.rx_busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", bus.rx_data); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.rx_busy); end
        checks++; if ({bus.rx_valid, bus.parity_err, bus.frame_err} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b%b%b expected 000", bus.rx_valid, bus.parity_err, bus.frame_err); end
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(8 * CPB);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL rstmid_strobes: got %0d expected 0", obs.size()); end
        send_frame(8'h81, ref_parity(8'h81), 1'b1, c0);
        idle(CPB + 4);
        checks++; if (obs.size() != 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", obs.size()); end
        if (obs.size() > 0) begin
            checks++; if (obs[0].data !== 8'h81) begin errors++; $display("FAIL rstmid_next_data: got %h expected 81", obs[0].data); end
            checks++; if ({obs[0].perr, obs[0].ferr} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %b%b expected 00", obs[0].perr, obs[0].ferr); end
        end
    endtask

    task automatic test_random();
        rec_t        exp_q[$];
        logic [7:0]  d;
        logic        pb;
        int unsigned c0;
        obs.delete();
        for (int n = 0; n < 10; n++) begin
            d  = 8'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0) ? ~ref_parity(d) : ref_parity(d);
            exp_q.push_back('{0, d, (pb != ref_parity(d)), 1'b0});
            send_frame(d, pb, 1'b1, c0);
            idle($urandom_range(0, 2 * CPB));
        end
        idle(CPB + 4);
        checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        if (obs.size() == exp_q.size()) begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs[i].data !== exp_q[i].data || obs[i].perr !== exp_q[i].perr || obs[i].ferr !== exp_q[i].ferr) begin
                    errors++;
                    $display("FAIL rand_frame[%0d]: got %h/%b/%b expected %h/%b/%b", i,
                             obs[i].data, obs[i].perr, obs[i].ferr, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
                end
            end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic();
        test_parity_err();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream peer of uart_tx.
- Deserialises one frame: start(0), 8 data bits LSB first, 1 parity bit, 1 stop(1).
- Presents the byte with a one-clock valid strobe plus parity and framing error flags.
- Runs on the system clock and samples at mid-bit by counting clocks, so high baud rates (few clocks per bit) work without oversampling.

Parameters:
- CLKS_PER_BIT, 4: system clocks per bit (24 MHz / 6 Mbaud); legal range >= 3.
- PARITY, 0: 0 = even (parity bit = ^data); 1 = odd (parity bit = ~^data). Must match the transmitter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART line; asynchronous to clk; idles high
- rx_data  out  8  last received byte
- rx_valid  out  1  one-clock strobe: a frame completed
- parity_err  out  1  parity mismatch on the last frame; valid with rx_valid, then held
- frame_err  out  1  stop bit sampled 0 on the last frame; valid with rx_valid, then held
- rx_busy  out  1  frame reception in progress

Behaviour:
- Reset (asynchronous, active-high) and its values:
  - state = IDLE; synchroniser flops = 1; cnt = 0; bit index = 0; shift register = 0.
  - rx_data = 0; rx_valid, parity_err, frame_err and rx_busy = 0.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. HALF = CLKS_PER_BIT/2 (integer).
- IDLE:
  - When rx_s == 0: cnt <= 0, go to START, rx_busy <= 1.
- START:
  - cnt increments; at cnt == HALF-1, sample the line.
  - Sample 0: cnt <= 0, go to DATA.
  - Sample 1: glitch; go to IDLE with rx_busy <= 0 and no strobe.
- DATA:
  - At cnt == CLKS_PER_BIT-1: sample, shift in at the MSB (LSB-first), cnt <= 0.
  - After the 8th bit, go to PARITY.
- PARITY:
  - At cnt == CLKS_PER_BIT-1: sample into parity flop, cnt <= 0, go to STOP.
- STOP, at cnt == CLKS_PER_BIT-1:
  - rx_data <= shift register; rx_valid <= 1 for exactly one clock.
  - parity_err <= (sampled parity != expected); frame_err <= (stop sample == 0).
  - Stop sample 1: go to IDLE with rx_busy <= 0.
  - Stop sample 0: go to WAIT_HIGH (line break or misframe).
- WAIT_HIGH:
  - Stay until rx_s == 1, then go to IDLE and rx_busy <= 0. This prevents a held-low line from retriggering frames.
- Timing, with E0 = the edge at which IDLE detects rx_s == 0:
  - Bit k (0..7) is sampled at E0 + HALF + (k+1)*CLKS_PER_BIT.
  - Parity is sampled at E0 + HALF + 9*CLKS_PER_BIT; stop at E0 + HALF + 10*CLKS_PER_BIT.
  - rx_valid is high in the cycle after the stop sample.
- rx_valid always fires on a complete frame, including error frames; the flags qualify it.
- rx_data and both flags hold until the next rx_valid.
- Back-to-back frames:
  - A start edge immediately after the stop sample is accepted.
  - No idle gap is required beyond the remaining half stop bit.

Optional Feature:
- UART_RX_MAJORITY_EN defined:
  - A 3-deep history of rx_s is kept.
  - Every sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s at that cycle and the two previous cycles.
  - Sample timing is unchanged; a single-clock glitch is rejected.
- Not defined: a single rx_s sample at each sample point.

Decomposition:
- Shared UART.vh header additions:
  - CLKS_PER_BIT constants per baud/clock pair (e.g. CLKS_6M_24M = 4).
  - Frame size: 1 start + 8 data + 1 parity + 1 stop.
  - Parity encoding: EVEN = 0, ODD = 1.
  - State encodings: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- One natural sub-module: uart_rx_sync, a 2-flop synchroniser that resets to 1 and also holds the majority history when enabled.

Test Plan:
- Byte 0xA5, even parity (bit = 0), stop = 1, CLKS_PER_BIT = 4 -> one rx_valid; rx_data = 0xA5; parity_err = 0; frame_err = 0; rx_busy falls after the strobe.
- Byte 0x01 with parity bit forced to 0 under PARITY = 0 (expected 1) -> rx_data = 0x01; parity_err = 1; frame_err = 0.
- Byte 0x3C with stop bit 0, then line held low 40 clocks before returning high -> one rx_valid, frame_err = 1. No second strobe while low; the next valid frame (0x55) is received correctly.
- rx low pulse of 1 clock while IDLE -> START sample reads 1; return to IDLE; no rx_valid; rx_busy pulses only.
- Three back-to-back frames 0x00, 0xFF, 0x7E with no idle gap -> three strobes spaced 11*CLKS_PER_BIT clocks apart, with correct data and clean flags.
- Reset asserted at the 4th data bit of frame 0x81 -> all outputs 0 immediately (asynchronous); no strobe. The next full frame 0x81 is received with clean flags.
